// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. Performance counter members exist
// only when HAZARD_PERF_CNT_EN is defined.
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] i_rs1_addr_dec;
    logic [REG_ADDR_W-1:0] i_rs2_addr_dec;
    logic [REG_ADDR_W-1:0] i_rs1_addr_exec;
    logic [REG_ADDR_W-1:0] i_rs2_addr_exec;
    logic [REG_ADDR_W-1:0] i_rd_addr_exec;
    logic [REG_ADDR_W-1:0] i_rd_addr_mem;
    logic [REG_ADDR_W-1:0] i_rd_addr_wb;
    logic                  i_reg_we_mem;
    logic                  i_reg_we_wb;
    logic                  i_pc_src_exec;
    logic                  i_load_instr;
    logic                  i_halt_req;
    logic                  o_stall_fetch;
    logic                  o_stall_dec;
    logic                  o_flush_dec;
    logic                  o_flush_exec;
    logic [1:0]            o_forward_rs1;
    logic [1:0]            o_forward_rs2;
    logic                  o_halt_ack;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]           o_stall_cnt;
    logic [31:0]           o_flush_cnt;
`endif

    // Pipeline side: drives stage information, receives control.
    modport master (
        output i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec,
        output i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb,
        output i_reg_we_mem, i_reg_we_wb, i_pc_src_exec, i_load_instr, i_halt_req,
        input  o_stall_fetch, o_stall_dec, o_flush_dec, o_flush_exec,
        input  o_forward_rs1, o_forward_rs2, o_halt_ack
`ifdef HAZARD_PERF_CNT_EN
        , input o_stall_cnt, o_flush_cnt
`endif
    );

    modport slave (
        input  i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec,
        input  i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb,
        input  i_reg_we_mem, i_reg_we_wb, i_pc_src_exec, i_load_instr, i_halt_req,
        output o_stall_fetch, o_stall_dec, o_flush_dec, o_flush_exec,
        output o_forward_rs1, o_forward_rs2, o_halt_ack
`ifdef HAZARD_PERF_CNT_EN
        , output o_stall_cnt, o_flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and halt/drain FSM.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    hazard_unit_if.slave hz
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             lu_stall;
    logic             stall_fetch, stall_dec, flush_dec, flush_exec, halt_ack;

    // Memory stage wins over write-back; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_mem,
        input logic                  we_mem,
        input logic [REG_ADDR_W-1:0] rd_wb,
        input logic                  we_wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_mem && (rd_mem != '0) && (rd_mem == rs)) begin
            sel = 2'b10;
        end else if (we_wb && (rd_wb != '0) && (rd_wb == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign hz.o_forward_rs1 = fwd_sel(hz.i_rs1_addr_exec, hz.i_rd_addr_mem, hz.i_reg_we_mem,
                                      hz.i_rd_addr_wb, hz.i_reg_we_wb);
    assign hz.o_forward_rs2 = fwd_sel(hz.i_rs2_addr_exec, hz.i_rd_addr_mem, hz.i_reg_we_mem,
                                      hz.i_rd_addr_wb, hz.i_reg_we_wb);

    always_comb begin
        lu_stall = hz.i_load_instr && (hz.i_rd_addr_exec != '0) &&
                   ((hz.i_rd_addr_exec == hz.i_rs1_addr_dec) ||
                    (hz.i_rd_addr_exec == hz.i_rs2_addr_dec));
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_fetch = 1'b0;
        stall_dec   = 1'b0;
        flush_dec   = 1'b0;
        flush_exec  = 1'b0;
        halt_ack    = 1'b0;
        case (state_q)
            RUN: begin
                // A redirect squashes the stalled instruction anyway, so it overrides the stall.
                if (hz.i_pc_src_exec) begin
                    flush_dec  = 1'b1;
                    flush_exec = 1'b1;
                end else if (lu_stall) begin
                    stall_fetch = 1'b1;
                    stall_dec   = 1'b1;
                    flush_exec  = 1'b1;
                end
                if (hz.i_halt_req && !hz.i_pc_src_exec && !lu_stall) begin
                    state_d = DRAIN;
                    drain_d = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                stall_fetch = 1'b1;
                stall_dec   = 1'b1;
                flush_exec  = 1'b1;
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            HALTED: begin
                stall_fetch = 1'b1;
                stall_dec   = 1'b1;
                flush_exec  = 1'b1;
                halt_ack    = 1'b1;
                if (!hz.i_halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign hz.o_stall_fetch = stall_fetch;
    assign hz.o_stall_dec   = stall_dec;
    assign hz.o_flush_dec   = flush_dec;
    assign hz.o_flush_exec  = flush_exec;
    assign hz.o_halt_ack    = halt_ack;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == RUN && stall_fetch) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (state_q == RUN && hz.i_pc_src_exec) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.o_stall_cnt = stall_cnt_q;
    assign hz.o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table for combinational behaviour,
// hand-written sequences for halt/drain, deferral and asynchronous reset.
module tb_hazard_unit;

    logic clk;
    logic arst_n;
    int   n_cmp;
    int   n_err;

    hazard_unit_if #(.REG_ADDR_W(5)) hif ();

    hazard_unit #(.REG_ADDR_W(5), .DRAIN_CYCLES(3)) dut (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .hz       (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       wem, wew, pc, ld;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[$];

    // Packed as {fwd1, fwd2, stall_fetch, stall_dec, flush_dec, flush_exec, halt_ack}
    function automatic logic [8:0] e(input logic [1:0] f1, input logic [1:0] f2,
                                     input logic sf, input logic sd, input logic fd,
                                     input logic fe, input logic ack);
        return {f1, f2, sf, sd, fd, fe, ack};
    endfunction

    function automatic vec_t mk(input string name,
                                input logic [4:0] rs1d, input logic [4:0] rs2d,
                                input logic [4:0] rs1e, input logic [4:0] rs2e,
                                input logic [4:0] rde, input logic [4:0] rdm,
                                input logic [4:0] rdw, input logic wem, input logic wew,
                                input logic pc, input logic ld, input logic [8:0] exp);
        vec_t v;
        v.name = name; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.wem = wem; v.wew = wew;
        v.pc = pc; v.ld = ld; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] actual();
        return {hif.o_forward_rs1, hif.o_forward_rs2, hif.o_stall_fetch, hif.o_stall_dec,
                hif.o_flush_dec, hif.o_flush_exec, hif.o_halt_ack};
    endfunction

    task automatic drive(input vec_t v);
        hif.i_rs1_addr_dec  = v.rs1d;
        hif.i_rs2_addr_dec  = v.rs2d;
        hif.i_rs1_addr_exec = v.rs1e;
        hif.i_rs2_addr_exec = v.rs2e;
        hif.i_rd_addr_exec  = v.rde;
        hif.i_rd_addr_mem   = v.rdm;
        hif.i_rd_addr_wb    = v.rdw;
        hif.i_reg_we_mem    = v.wem;
        hif.i_reg_we_wb     = v.wew;
        hif.i_pc_src_exec   = v.pc;
        hif.i_load_instr    = v.ld;
    endtask

    task automatic idle();
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    endtask

    task automatic pop_compare();
        sb_t s;
        logic [8:0] a;
        if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        s = sb_q.pop_front();
        a = actual();
        n_cmp++;
        if (a !== s.exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (fwd1,fwd2,sf,sd,fd,fe,ack)", s.name, a, s.exp);
        end
    endtask

    // Inputs are already driven (posedge+1); compare on the following negedge.
    task automatic do_cycle(input string name, input logic [8:0] exp);
        sb_t s;
        s.name = name; s.exp = exp;
        sb_q.push_back(s);
        @(negedge clk);
        pop_compare();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [8:0] exp);
        sb_t s;
        s.name = name; s.exp = exp;
        sb_q.push_back(s);
        #1;
        pop_compare();
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    localparam logic [8:0] ZERO = 9'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] drn, hlt, br, lu;
        n_cmp  = 0;
        n_err  = 0;
        drn = e(0, 0, 1, 1, 0, 1, 0);
        hlt = e(0, 0, 1, 1, 0, 1, 1);
        br  = e(0, 0, 0, 0, 1, 1, 0);
        lu  = e(0, 0, 1, 1, 0, 1, 0);

        arst_n = 1'b0;
        hif.i_halt_req = 1'b0;
        idle();

        // Reset: RUN rules apply combinationally, no halt ack.
        repeat (2) @(posedge clk);
        #1;
        drive(mk("rst_lu", 0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 1, '0));
        check_now("reset_loaduse", lu);
        idle();
        check_now("reset_idle", ZERO);
`ifdef HAZARD_PERF_CNT_EN
        check_val("reset_stall_cnt", hif.o_stall_cnt, 32'd0);
        check_val("reset_flush_cnt", hif.o_flush_cnt, 32'd0);
`endif
        arst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef HAZARD_PERF_CNT_EN
        drive(mk("perf_br_lu", 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, '0));
        do_cycle("perf_br_lu", br);
        check_val("perf_flush_cnt", hif.o_flush_cnt, 32'd1);
        check_val("perf_stall_cnt", hif.o_stall_cnt, 32'd0);
        drive(mk("perf_lu", 0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 1, '0));
        do_cycle("perf_lu", lu);
        check_val("perf_stall_cnt2", hif.o_stall_cnt, 32'd1);
        check_val("perf_flush_cnt2", hif.o_flush_cnt, 32'd1);
`endif

        //        name           rs1d rs2d rs1e rs2e rde rdm rdw wem wew pc ld  expected
        vecs.push_back(mk("fwd_mem",     0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, e(2, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("fwd_wb",      0, 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, e(1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("fwd_rs_zero", 0, 0, 0, 0, 0, 5, 5, 1, 1, 0, 0, ZERO));
        vecs.push_back(mk("fwd_rs2_mem", 0, 0, 0, 9, 0, 9, 0, 1, 0, 0, 0, e(0, 2, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("fwd_we_off",  0, 0, 0, 9, 0, 9, 9, 0, 1, 0, 0, e(0, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("fwd_both",    0, 0, 3, 4, 0, 3, 4, 1, 1, 0, 0, e(2, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("fwd_none",    0, 0, 3, 4, 0, 3, 4, 0, 0, 0, 0, ZERO));
        vecs.push_back(mk("lu_rs2",      0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 1, lu));
        vecs.push_back(mk("lu_gone",     0, 7, 0, 0, 8, 0, 0, 0, 0, 0, 1, ZERO));
        vecs.push_back(mk("lu_rs1",      7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 1, lu));
        vecs.push_back(mk("lu_rd_zero",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ZERO));
        vecs.push_back(mk("lu_no_load",  0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, ZERO));
        vecs.push_back(mk("br_over_lu",  0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, br));
        vecs.push_back(mk("br_only",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, br));
        vecs.push_back(mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            do_cycle(vecs[i].name, vecs[i].exp);
        end

        // Halt held: RUN cycle, three DRAIN cycles, then HALTED until released.
        idle();
        hif.i_halt_req = 1'b1;
        do_cycle("halt_req_run", ZERO);
        for (int i = 0; i < 3; i++) do_cycle($sformatf("halt_drain%0d", i + 1), drn);
        do_cycle("halted_ack", hlt);
        drive(mk("halted_ignore", 0, 7, 5, 0, 7, 5, 0, 1, 0, 1, 1, '0));
        do_cycle("halted_ignore_fwd", e(2, 0, 1, 1, 0, 1, 1));
        idle();
        hif.i_halt_req = 1'b0;
        do_cycle("halt_drop_still_ack", hlt);
        do_cycle("halt_released", ZERO);

        // Halt dropped during drain: drain completes, one HALTED cycle, back to RUN.
        hif.i_halt_req = 1'b1;
        do_cycle("abort_run", ZERO);
        hif.i_halt_req = 1'b0;
        for (int i = 0; i < 3; i++) do_cycle($sformatf("abort_drain%0d", i + 1), drn);
        do_cycle("abort_halted", hlt);
        do_cycle("abort_run_again", ZERO);

        // Halt deferred by a redirect, then reset in drain cycle 2.
        hif.i_halt_req = 1'b1;
        hif.i_pc_src_exec = 1'b1;
        do_cycle("defer_branch", br);
        hif.i_pc_src_exec = 1'b0;
        do_cycle("defer_still_run", ZERO);
        do_cycle("defer_drain1", drn);
        check_now("defer_drain2", drn);
        arst_n = 1'b0;
        check_now("async_reset_run", ZERO);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) do_cycle($sformatf("post_rst_drain%0d", i + 1), drn);
        do_cycle("post_rst_halted", hlt);
        hif.i_halt_req = 1'b0;
        do_cycle("post_rst_drop", hlt);
        do_cycle("post_rst_run", ZERO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
